// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle between the master ports and the round-robin bus arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int MS_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0] approval_request;
    logic [NUM_MASTERS-1:0] tx_slave_select;
    logic [NUM_MASTERS-1:0] trans_done;
    logic [NUM_MASTERS-1:0] approval_grant;
    logic                   arbitor_busy;
    logic                   bus_busy;
    logic [MS_W-1:0]        master_sel;
    logic [NUM_SLAVES-1:0]  slave_en;
    logic                   sel_error;

    modport master (
        output approval_request, tx_slave_select, trans_done,
        input  approval_grant, arbitor_busy, bus_busy, master_sel, slave_en, sel_error
    );

    modport slave (
        input  approval_request, tx_slave_select, trans_done,
        output approval_grant, arbitor_busy, bus_busy, master_sel, slave_en, sel_error
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin serial bus arbiter: grants one master, shifts in its slave index LSB first,
// enables the decoded slave until trans_done or timeout, then releases the bus for one cycle.
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int SLAVE_LEN   = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int TIMEOUT     = 4095
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int MS_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BC_W = $clog2(SLAVE_LEN + 1);
    localparam int SL1  = SLAVE_LEN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_CONNECT,
        S_RELEASE
    } state_t;

    state_t                 state_reg, state_next;
    logic [MS_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [MS_W-1:0]        master_sel_reg, master_sel_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [SLAVE_LEN-1:0]   shift_reg, shift_next;
    logic [BC_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [11:0]            tmo_cnt_reg, tmo_cnt_next;
    logic [NUM_SLAVES-1:0]  slave_en_reg, slave_en_next;
    logic                   sel_error_reg, sel_error_next;
    logic                   bus_busy_reg, bus_busy_next;
    logic                   arb_busy_reg, arb_busy_next;

    logic                   found;
    logic [MS_W-1:0]        winner;
    logic [NUM_MASTERS-1:0] winner_oh;
    logic                   sel_bit;
    logic [SLAVE_LEN-1:0]   index_full;
    logic                   index_ok;
    logic [NUM_SLAVES-1:0]  slave_hit;

    // Search starts just after the last winner so the previous owner is considered last.
    always_comb begin
        int cand;
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = (int'(rr_ptr_reg) + i) % NUM_MASTERS;
            if (!found && bus.approval_request[MS_W'(cand)]) begin
                found  = 1'b1;
                winner = MS_W'(cand);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_winner_oh
            assign winner_oh[gi] = (winner == MS_W'(gi));
        end
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave_dec
            assign slave_hit[gi] = (index_full == SLAVE_LEN'(gi));
        end
    endgenerate

    // Index including the bit being sampled this cycle, so the decode is ready on the last edge.
    assign sel_bit = bus.tx_slave_select[master_sel_reg];

    always_comb begin
        index_full              = shift_reg;
        index_full[bit_cnt_reg] = sel_bit;
    end

    assign index_ok = ({1'b0, index_full} < SL1'(NUM_SLAVES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            rr_ptr_reg     <= MS_W'(NUM_MASTERS - 1);
            master_sel_reg <= '0;
            grant_reg      <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            slave_en_reg   <= '0;
            sel_error_reg  <= 1'b0;
            bus_busy_reg   <= 1'b0;
            arb_busy_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            master_sel_reg <= master_sel_next;
            grant_reg      <= grant_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            slave_en_reg   <= slave_en_next;
            sel_error_reg  <= sel_error_next;
            bus_busy_reg   <= bus_busy_next;
            arb_busy_reg   <= arb_busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        master_sel_next = master_sel_reg;
        grant_next      = grant_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        slave_en_next   = slave_en_reg;
        sel_error_next  = 1'b0;
        bus_busy_next   = bus_busy_reg;
        arb_busy_next   = arb_busy_reg;

        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    state_next      = S_ADDR;
                    grant_next      = winner_oh;
                    master_sel_next = winner;
                    rr_ptr_next     = winner;
                    arb_busy_next   = 1'b1;
                    bit_cnt_next    = '0;
                    shift_next      = '0;
                end
            end
            S_ADDR: begin
                if (!bus.approval_request[master_sel_reg]) begin
                    state_next = S_RELEASE;
                    grant_next = '0;
                end else begin
                    shift_next   = index_full;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BC_W'(SLAVE_LEN - 1)) begin
                        if (index_ok) begin
                            state_next    = S_CONNECT;
                            slave_en_next = slave_hit;
                            bus_busy_next = 1'b1;
                            tmo_cnt_next  = '0;
                        end else begin
                            state_next     = S_RELEASE;
                            sel_error_next = 1'b1;
                            grant_next     = '0;
                        end
                    end
                end
            end
            S_CONNECT: begin
                // Only the owner's trans_done counts; other masters' pulses are ignored.
                if (bus.trans_done[master_sel_reg]) begin
                    state_next    = S_RELEASE;
                    grant_next    = '0;
                    slave_en_next = '0;
                    bus_busy_next = 1'b0;
                end else if (tmo_cnt_reg == 12'(TIMEOUT - 1)) begin
                    state_next     = S_RELEASE;
                    sel_error_next = 1'b1;
                    grant_next     = '0;
                    slave_en_next  = '0;
                    bus_busy_next  = 1'b0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_RELEASE: begin
                state_next    = S_IDLE;
                grant_next    = '0;
                slave_en_next = '0;
                bus_busy_next = 1'b0;
                arb_busy_next = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.approval_grant = grant_reg;
    assign bus.arbitor_busy   = arb_busy_reg;
    assign bus.bus_busy       = bus_busy_reg;
    assign bus.master_sel     = master_sel_reg;
    assign bus.slave_en       = slave_en_reg;
    assign bus.sel_error      = sel_error_reg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: tenures, round-robin, bad index, timeout, reset abort.
module tb_bus_arbiter;
    localparam int NM = 2;
    localparam int SL = 2;
    localparam int NS = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_if ();

    bus_arbiter #(
        .NUM_MASTERS(NM),
        .SLAVE_LEN  (SL),
        .NUM_SLAVES (NS),
        .TIMEOUT    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(bus_if.approval_grant), 0);
        check({tag, "_arb_busy"}, 32'(bus_if.arbitor_busy), 0);
        check({tag, "_bus_busy"}, 32'(bus_if.bus_busy), 0);
        check({tag, "_master_sel"}, 32'(bus_if.master_sel), 0);
        check({tag, "_slave_en"}, 32'(bus_if.slave_en), 0);
        check({tag, "_sel_error"}, 32'(bus_if.sel_error), 0);
    endtask

    task automatic send_index(input int m, input int idx);
        for (int b = 0; b < SL; b++) begin
            bus_if.tx_slave_select    = '0;
            bus_if.tx_slave_select[m] = idx[b];
            tick();
        end
        bus_if.tx_slave_select = '0;
    endtask

    // Starts in IDLE with requests already driven; ends back in IDLE.
    task automatic tenure(input string tag, input int m, input int idx, input int hold,
                          input bit foreign);
        tick();
        check({tag, "_grant"}, 32'(bus_if.approval_grant), 1 << m);
        check({tag, "_master_sel"}, 32'(bus_if.master_sel), m);
        check({tag, "_arb_busy"}, 32'(bus_if.arbitor_busy), 1);
        check({tag, "_addr_bus_busy"}, 32'(bus_if.bus_busy), 0);
        send_index(m, idx);
        check({tag, "_slave_en"}, 32'(bus_if.slave_en), 1 << idx);
        check({tag, "_bus_busy"}, 32'(bus_if.bus_busy), 1);
        for (int c = 1; c < hold; c++) begin
            if (foreign && c == 2) bus_if.trans_done[1 - m] = 1'b1;
            tick();
            bus_if.trans_done = '0;
        end
        if (foreign) begin
            check({tag, "_foreign_bus_busy"}, 32'(bus_if.bus_busy), 1);
            check({tag, "_foreign_grant"}, 32'(bus_if.approval_grant), 1 << m);
        end
        bus_if.trans_done[m] = 1'b1;
        tick();
        bus_if.trans_done = '0;
        check({tag, "_rel_grant"}, 32'(bus_if.approval_grant), 0);
        check({tag, "_rel_slave_en"}, 32'(bus_if.slave_en), 0);
        check({tag, "_rel_bus_busy"}, 32'(bus_if.bus_busy), 0);
        check({tag, "_rel_arb_busy"}, 32'(bus_if.arbitor_busy), 1);
        tick();
        check({tag, "_idle_arb_busy"}, 32'(bus_if.arbitor_busy), 0);
        $display("%s: tenure master=%0d slave=%0d hold=%0d", tag, m, idx, hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.approval_request = '0;
        bus_if.tx_slave_select  = '0;
        bus_if.trans_done       = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        $display("reset: outputs checked");
        reset = 1'b0;
        tick();

        // T1: single master, index 1, done after 10 connect cycles
        bus_if.approval_request = 2'b01;
        tenure("T1", 0, 1, 10, 1'b0);
        bus_if.approval_request = '0;

        // T2: both request continuously from reset; alternation 0,1,0,1
        do_reset();
        bus_if.approval_request = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tenure("T2", k % 2, k % 3, 3, 1'b0);
        end
        bus_if.approval_request = '0;

        // T3: invalid index 3 from master 0 (rr_ptr=1 after T2)
        bus_if.approval_request = 2'b01;
        tick();
        check("T3_grant", 32'(bus_if.approval_grant), 1);
        send_index(0, 3);
        bus_if.approval_request = '0;
        check("T3_sel_error", 32'(bus_if.sel_error), 1);
        check("T3_slave_en", 32'(bus_if.slave_en), 0);
        check("T3_bus_busy", 32'(bus_if.bus_busy), 0);
        check("T3_rel_grant", 32'(bus_if.approval_grant), 0);
        tick();
        check("T3_sel_error_pulse", 32'(bus_if.sel_error), 0);
        check("T3_idle_arb_busy", 32'(bus_if.arbitor_busy), 0);
        $display("T3: invalid slave index rejected");

        // T4: master 1 connects to slave 0 and never finishes -> timeout after 16 cycles
        bus_if.approval_request = 2'b10;
        tick();
        check("T4_grant", 32'(bus_if.approval_grant), 2);
        send_index(1, 0);
        check("T4_slave_en", 32'(bus_if.slave_en), 1);
        for (int c = 0; c < 15; c++) tick();
        check("T4_busy_c16", 32'(bus_if.bus_busy), 1);
        check("T4_no_err_c16", 32'(bus_if.sel_error), 0);
        tick();
        check("T4_timeout_err", 32'(bus_if.sel_error), 1);
        check("T4_timeout_grant", 32'(bus_if.approval_grant), 0);
        check("T4_timeout_bus_busy", 32'(bus_if.bus_busy), 0);
        bus_if.approval_request = '0;
        tick();
        check("T4_err_pulse", 32'(bus_if.sel_error), 0);
        check("T4_idle_arb_busy", 32'(bus_if.arbitor_busy), 0);
        $display("T4: timeout release of master 1");

        // T5: foreign trans_done during master 0's connect is ignored
        bus_if.approval_request = 2'b01;
        tenure("T5", 0, 2, 6, 1'b1);
        bus_if.approval_request = '0;

        // Owner drops request during ADDR -> quiet release
        bus_if.approval_request = 2'b01;
        tick();
        check("T7_grant", 32'(bus_if.approval_grant), 1);
        bus_if.approval_request = '0;
        tick();
        check("T7_rel_grant", 32'(bus_if.approval_grant), 0);
        check("T7_no_err", 32'(bus_if.sel_error), 0);
        check("T7_rel_arb_busy", 32'(bus_if.arbitor_busy), 1);
        tick();
        check("T7_idle_arb_busy", 32'(bus_if.arbitor_busy), 0);
        $display("T7: request withdrawn during address phase");

        // T6: reset mid-connect; afterwards rr_ptr is back so master 0 wins again
        bus_if.approval_request = 2'b01;
        tick();
        send_index(0, 1);
        tick();
        check("T6_pre_bus_busy", 32'(bus_if.bus_busy), 1);
        reset = 1'b1;
        tick();
        check_reset_outputs("T6");
        reset = 1'b0;
        bus_if.approval_request = 2'b11;
        tick();
        check("T6_grant_after_reset", 32'(bus_if.approval_grant), 1);
        check("T6_sel_after_reset", 32'(bus_if.master_sel), 0);
        bus_if.approval_request = '0;
        $display("T6: reset abort, master 0 granted first afterwards");

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
